// File: rtl/enigma_rotor_stage.sv
// One Enigma rotor: registered position/ring, one-hot forward and backward
// substitution with one-cycle latency, and carry / double-step generation.
module enigma_rotor_stage #(
  parameter int ROTOR_SEL   = 0,
  parameter bit DOUBLE_STEP = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [4:0]  load_pos,
  input  logic [4:0]  load_ring,
  input  logic        step_in,
  input  logic        key_step,
  output logic        step_out,
  output logic [4:0]  pos,
  input  logic        fwd_valid,
  input  logic [25:0] fwd_in,
  output logic        fwd_out_valid,
  output logic [25:0] fwd_out,
  input  logic        bwd_valid,
  input  logic [25:0] bwd_in,
  output logic        bwd_out_valid,
  output logic [25:0] bwd_out
);

  // Wiring stored as ASCII: the letter for contact c sits at byte (25 - c).
  localparam logic [207:0] WIRING =
    (ROTOR_SEL == 1) ? "AJDKSIRUXBLHWTMCQGZNPYFVOE" :
    (ROTOR_SEL == 2) ? "BDFHJLCPRTXVZNOYEQIKGWAUMS" :
                       "EKMFLGDQVZNTOWYHXUSPAIBRCJ";
  localparam logic [4:0] NOTCH =
    (ROTOR_SEL == 1) ? 5'd4 : (ROTOR_SEL == 2) ? 5'd21 : 5'd16;

  logic [4:0]  ring;
  logic [4:0]  offset;
  logic        at_notch;
  logic        adv;
  logic [25:0] fwd_sub;
  logic [25:0] bwd_sub;

  function automatic logic [4:0] wire_at(input logic [4:0] c);
    logic [4:0] idx;
    logic [7:0] ch;
    idx = 5'd25 - c;
    ch  = WIRING[{idx, 3'b000} +: 8];
    return 5'(ch - 8'd65);
  endfunction

  function automatic logic [25:0] rotl26(input logic [25:0] v, input logic [4:0] s);
    return 26'(({v, v} << s) >> 6'd26);
  endfunction

  function automatic logic [25:0] rotr26(input logic [25:0] v, input logic [4:0] s);
    return 26'({v, v} >> s);
  endfunction

  function automatic logic [25:0] permute(input logic [25:0] v, input logic inverse);
    logic [25:0] r;
    logic [4:0]  c;
    logic [4:0]  w;
    r = 26'd0;
    for (int i = 0; i < 26; i++) begin
      c = 5'(i);
      w = wire_at(c);
      if (inverse) r[c] = v[w];
      else         r[w] = v[c];
    end
    return r;
  endfunction

  // Rotate into the wiring frame, substitute, rotate back; malformed input gives zero.
  function automatic logic [25:0] substitute(input logic [25:0] v, input logic [4:0] s,
                                             input logic inverse);
    if (!$onehot(v)) return 26'd0;
    return rotr26(permute(rotl26(v, s), inverse), s);
  endfunction

  assign offset   = (pos >= ring) ? 5'(pos - ring) : 5'(pos + 5'd26 - ring);
  assign at_notch = (pos == NOTCH);
  assign adv      = step_in | (DOUBLE_STEP & key_step & at_notch);
  assign fwd_sub  = substitute(fwd_in, offset, 1'b0);
  assign bwd_sub  = substitute(bwd_in, offset, 1'b1);

  // Rotor state, carry pulse and both registered substitution paths.
  always_ff @(posedge clk) begin
    if (reset) begin
      pos           <= 5'd0;
      ring          <= 5'd0;
      step_out      <= 1'b0;
      fwd_out_valid <= 1'b0;
      fwd_out       <= 26'd0;
      bwd_out_valid <= 1'b0;
      bwd_out       <= 26'd0;
    end else begin
      fwd_out_valid <= fwd_valid;
      bwd_out_valid <= bwd_valid;
      if (fwd_valid) fwd_out <= fwd_sub;
      if (bwd_valid) bwd_out <= bwd_sub;
      if (load) begin
        pos      <= load_pos;
        ring     <= load_ring;
        step_out <= 1'b0;
      end else if (adv) begin
        pos      <= (pos == 5'd25) ? 5'd0 : 5'(pos + 5'd1);
        step_out <= at_notch;
      end else begin
        step_out <= 1'b0;
      end
    end
  end

  enigma_rotor_stage_chk #(.ROTOR_SEL(ROTOR_SEL)) u_chk (.clk(clk));

endmodule

// Configuration checker: only rotors I..III exist.
module enigma_rotor_stage_chk #(
  parameter int ROTOR_SEL = 0
) (
  input logic clk
);
  localparam bit SEL_OK = (ROTOR_SEL >= 0) && (ROTOR_SEL <= 2);

  a_rotor_sel: assert property (@(posedge clk) SEL_OK);
endmodule

// File: tb/tb_enigma_rotor_stage.sv
// Directed bench: rotor I (no double step) and rotor II (double step) side by side.
module tb_enigma_rotor_stage;
  logic        clk = 1'b0;
  logic        reset, load, step_in, key_step, fwd_valid, bwd_valid;
  logic [4:0]  load_pos, load_ring;
  logic [25:0] fwd_in, bwd_in;
  logic        step_out0, fv0, bv0, step_out1, fv1, bv1;
  logic [4:0]  pos0, pos1;
  logic [25:0] fo0, bo0, fo1, bo1;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  enigma_rotor_stage #(.ROTOR_SEL(0), .DOUBLE_STEP(1'b0)) u_r0 (
    .clk(clk), .reset(reset), .load(load), .load_pos(load_pos), .load_ring(load_ring),
    .step_in(step_in), .key_step(key_step), .step_out(step_out0), .pos(pos0),
    .fwd_valid(fwd_valid), .fwd_in(fwd_in), .fwd_out_valid(fv0), .fwd_out(fo0),
    .bwd_valid(bwd_valid), .bwd_in(bwd_in), .bwd_out_valid(bv0), .bwd_out(bo0));

  enigma_rotor_stage #(.ROTOR_SEL(1), .DOUBLE_STEP(1'b1)) u_r1 (
    .clk(clk), .reset(reset), .load(load), .load_pos(load_pos), .load_ring(load_ring),
    .step_in(step_in), .key_step(key_step), .step_out(step_out1), .pos(pos1),
    .fwd_valid(fwd_valid), .fwd_in(fwd_in), .fwd_out_valid(fv1), .fwd_out(fo1),
    .bwd_valid(bwd_valid), .bwd_in(bwd_in), .bwd_out_valid(bv1), .bwd_out(bo1));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    reset = 1'b0; load = 1'b0; step_in = 1'b0; key_step = 1'b0;
    fwd_valid = 1'b0; bwd_valid = 1'b0;
    load_pos = 5'd0; load_ring = 5'd0; fwd_in = 26'd0; bwd_in = 26'd0;
  endtask

  task automatic do_load(input logic [4:0] p, input logic [4:0] r);
    load = 1'b1; load_pos = p; load_ring = r;
    tick();
    load = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    reset = 1'b1; fwd_valid = 1'b1; fwd_in = 26'h1;
    tick();
    idle();
    total++; if (pos0 !== 5'd0) begin bad++; $display("FAIL reset_pos actual=%0d required=0", pos0); end
    total++; if (step_out0 !== 1'b0) begin bad++; $display("FAIL reset_step_out actual=%b required=0", step_out0); end
    total++; if ({fv0, bv0} !== 2'b00) begin bad++; $display("FAIL reset_valids actual=%b required=00", {fv0, bv0}); end
    total++; if ({fo0, bo0} !== 52'd0) begin bad++; $display("FAIL reset_data actual=%h required=0", {fo0, bo0}); end
    total++; if (pos1 !== 5'd0) begin bad++; $display("FAIL reset_pos1 actual=%0d required=0", pos1); end
  endtask

  task automatic test_fwd_basic();
    fwd_valid = 1'b1; fwd_in = 26'h1;
    tick();
    fwd_valid = 1'b0; fwd_in = 26'h3;
    total++; if (fv0 !== 1'b1) begin bad++; $display("FAIL fwd_valid_lat actual=%b required=1", fv0); end
    total++; if (fo0 !== 26'h10) begin bad++; $display("FAIL fwd_a_to_e actual=%h required=%h", fo0, 26'h10); end
    total++; if (fo1 !== 26'h1) begin bad++; $display("FAIL fwd2_a_to_a actual=%h required=%h", fo1, 26'h1); end
    tick();
    total++; if (fv0 !== 1'b0) begin bad++; $display("FAIL fwd_valid_drop actual=%b required=0", fv0); end
    total++; if (fo0 !== 26'h10) begin bad++; $display("FAIL fwd_hold actual=%h required=%h", fo0, 26'h10); end
  endtask

  task automatic test_ring();
    do_load(5'd0, 5'd1);
    total++; if (pos0 !== 5'd0) begin bad++; $display("FAIL ring_load_pos actual=%0d required=0", pos0); end
    fwd_valid = 1'b1; fwd_in = 26'h1;
    tick();
    fwd_valid = 1'b0;
    total++; if (fo0 !== 26'h400) begin bad++; $display("FAIL ring_a_to_k actual=%h required=%h", fo0, 26'h400); end
    step_in = 1'b1;
    tick();
    step_in = 1'b0;
    total++; if (pos0 !== 5'd1) begin bad++; $display("FAIL ring_step_pos actual=%0d required=1", pos0); end
    fwd_valid = 1'b1; fwd_in = 26'h1;
    tick();
    fwd_valid = 1'b0;
    total++; if (fo0 !== 26'h10) begin bad++; $display("FAIL ring_stepped_a_to_e actual=%h required=%h", fo0, 26'h10); end
  endtask

  task automatic test_bwd();
    do_load(5'd0, 5'd0);
    fwd_valid = 1'b1; fwd_in = 26'h2; bwd_valid = 1'b1; bwd_in = 26'h10;
    tick();
    fwd_valid = 1'b0; bwd_valid = 1'b0;
    total++; if (bv0 !== 1'b1) begin bad++; $display("FAIL bwd_valid_lat actual=%b required=1", bv0); end
    total++; if (bo0 !== 26'h1) begin bad++; $display("FAIL bwd_e_to_a actual=%h required=%h", bo0, 26'h1); end
    total++; if (fo0 !== 26'h400) begin bad++; $display("FAIL fwd_b_to_k actual=%h required=%h", fo0, 26'h400); end
    total++; if (bo1 !== 26'h2000000) begin bad++; $display("FAIL bwd2_e_to_z actual=%h required=%h", bo1, 26'h2000000); end
    total++; if (fo1 !== 26'h200) begin bad++; $display("FAIL fwd2_b_to_j actual=%h required=%h", fo1, 26'h200); end
    do_load(5'd1, 5'd0);
    fwd_valid = 1'b1; fwd_in = 26'h1; bwd_valid = 1'b1; bwd_in = 26'h200;
    tick();
    fwd_valid = 1'b0; bwd_valid = 1'b0;
    total++; if (fo0 !== 26'h200) begin bad++; $display("FAIL fwd_pos1_a_to_j actual=%h required=%h", fo0, 26'h200); end
    total++; if (bo0 !== 26'h1) begin bad++; $display("FAIL bwd_pos1_j_to_a actual=%h required=%h", bo0, 26'h1); end
    total++; if (fo1 !== 26'h100) begin bad++; $display("FAIL fwd2_pos1_a_to_i actual=%h required=%h", fo1, 26'h100); end
  endtask

  task automatic test_roundtrip();
    logic [4:0]  pos_tab  [10] = '{5'd3, 5'd7, 5'd11, 5'd16, 5'd19, 5'd22, 5'd25, 5'd0, 5'd13, 5'd8};
    logic [4:0]  ring_tab [10] = '{5'd5, 5'd0, 5'd20, 5'd16, 5'd2, 5'd24, 5'd1, 5'd25, 5'd13, 5'd9};
    logic [25:0] letter, mid;
    for (int k = 0; k < 10; k++) begin
      do_load(pos_tab[k], ring_tab[k]);
      for (int x = 0; x < 26; x++) begin
        letter = 26'd1 << x;
        fwd_valid = 1'b1; fwd_in = letter;
        tick();
        fwd_valid = 1'b0;
        mid = fo0;
        total++; if (!$onehot(mid)) begin bad++; $display("FAIL rt_fwd_onehot set=%0d x=%0d actual=%h", k, x, mid); end
        bwd_valid = 1'b1; bwd_in = mid;
        tick();
        bwd_valid = 1'b0;
        total++; if (bo0 !== letter) begin bad++; $display("FAIL rt_inverse set=%0d x=%0d actual=%h required=%h", k, x, bo0, letter); end
      end
    end
  endtask

  task automatic test_step();
    do_load(5'd16, 5'd0);
    step_in = 1'b1;
    tick();
    step_in = 1'b0;
    total++; if (pos0 !== 5'd17) begin bad++; $display("FAIL notch_pos actual=%0d required=17", pos0); end
    total++; if (step_out0 !== 1'b1) begin bad++; $display("FAIL notch_carry actual=%b required=1", step_out0); end
    tick();
    total++; if (step_out0 !== 1'b0) begin bad++; $display("FAIL carry_one_cycle actual=%b required=0", step_out0); end
    do_load(5'd25, 5'd0);
    step_in = 1'b1;
    tick();
    step_in = 1'b0;
    total++; if (pos0 !== 5'd0) begin bad++; $display("FAIL wrap_pos actual=%0d required=0", pos0); end
    total++; if (step_out0 !== 1'b0) begin bad++; $display("FAIL wrap_no_carry actual=%b required=0", step_out0); end
    load = 1'b1; load_pos = 5'd16; step_in = 1'b1;
    tick();
    load = 1'b0; step_in = 1'b0;
    total++; if (pos0 !== 5'd16) begin bad++; $display("FAIL load_wins_pos actual=%0d required=16", pos0); end
    total++; if (step_out0 !== 1'b0) begin bad++; $display("FAIL load_wins_carry actual=%b required=0", step_out0); end
    do_load(5'd15, 5'd0);
    step_in = 1'b1;
    tick();
    total++; if ({pos0, step_out0} !== {5'd16, 1'b0}) begin bad++; $display("FAIL b2b_first actual=%0d/%b required=16/0", pos0, step_out0); end
    tick();
    step_in = 1'b0;
    total++; if ({pos0, step_out0} !== {5'd17, 1'b1}) begin bad++; $display("FAIL b2b_second actual=%0d/%b required=17/1", pos0, step_out0); end
    tick();
    total++; if ({pos0, step_out0} !== {5'd17, 1'b0}) begin bad++; $display("FAIL b2b_idle actual=%0d/%b required=17/0", pos0, step_out0); end
  endtask

  task automatic test_double_step();
    do_load(5'd4, 5'd0);
    key_step = 1'b1;
    tick();
    key_step = 1'b0;
    total++; if (pos1 !== 5'd5) begin bad++; $display("FAIL dstep_pos actual=%0d required=5", pos1); end
    total++; if (step_out1 !== 1'b1) begin bad++; $display("FAIL dstep_carry actual=%b required=1", step_out1); end
    total++; if (pos0 !== 5'd4) begin bad++; $display("FAIL no_dstep_pos actual=%0d required=4", pos0); end
    tick();
    total++; if (step_out1 !== 1'b0) begin bad++; $display("FAIL dstep_one_cycle actual=%b required=0", step_out1); end
    key_step = 1'b1;
    tick();
    key_step = 1'b0;
    total++; if ({pos1, step_out1} !== {5'd5, 1'b0}) begin bad++; $display("FAIL dstep_off_notch actual=%0d/%b required=5/0", pos1, step_out1); end
  endtask

  task automatic test_bad_onehot();
    fwd_valid = 1'b1; fwd_in = 26'h3; bwd_valid = 1'b1; bwd_in = 26'h0;
    tick();
    fwd_valid = 1'b0; bwd_valid = 1'b0;
    total++; if ({fv0, fo0} !== {1'b1, 26'd0}) begin bad++; $display("FAIL two_hot actual=%b/%h required=1/0", fv0, fo0); end
    total++; if ({bv0, bo0} !== {1'b1, 26'd0}) begin bad++; $display("FAIL zero_hot actual=%b/%h required=1/0", bv0, bo0); end
  endtask

  task automatic test_reset_mid();
    do_load(5'd7, 5'd3);
    fwd_valid = 1'b1; fwd_in = 26'h1;
    tick();
    reset = 1'b1; bwd_valid = 1'b1; bwd_in = 26'h1;
    tick();
    idle();
    total++; if ({fv0, bv0} !== 2'b00) begin bad++; $display("FAIL mid_reset_valids actual=%b required=00", {fv0, bv0}); end
    total++; if ({fo0, bo0} !== 52'd0) begin bad++; $display("FAIL mid_reset_data actual=%h required=0", {fo0, bo0}); end
    total++; if ({pos0, step_out0} !== 6'd0) begin bad++; $display("FAIL mid_reset_pos actual=%0d/%b required=0/0", pos0, step_out0); end
    fwd_valid = 1'b1; fwd_in = 26'h1;
    tick();
    fwd_valid = 1'b0;
    total++; if (fo0 !== 26'h10) begin bad++; $display("FAIL mid_reset_ring_cleared actual=%h required=%h", fo0, 26'h10); end
  endtask

  initial begin
    idle();
    test_reset();
    test_fwd_basic();
    test_ring();
    test_bwd();
    test_roundtrip();
    test_step();
    test_double_step();
    test_bad_onehot();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
